// File: rtl/cpu_axi_bridge.sv
// Bridges the core's SRAM-like inst (read-only) and data (read/write) ports onto one
// single-beat AXI master with one outstanding read and one outstanding write.
module cpu_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_sram_req,
    input  logic                inst_sram_wr,
    input  logic [1:0]          inst_sram_size,
    input  logic [ADDR_W-1:0]   inst_sram_addr,
    output logic                inst_sram_addr_ok,
    output logic                inst_sram_data_ok,
    output logic [DATA_W-1:0]   inst_sram_rdata,

    input  logic                data_sram_req,
    input  logic                data_sram_wr,
    input  logic [1:0]          data_sram_size,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W/8-1:0] data_sram_wstrb,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic                data_sram_addr_ok,
    output logic                data_sram_data_ok,
    output logic [DATA_W-1:0]   data_sram_rdata,

    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,

    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rvalid,
    output logic                rready,

    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,

    output logic [3:0]          wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic                bvalid,
    output logic                bready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_AR   = 2'd1,
        RD_R    = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_AW_W = 2'd1,
        WR_B    = 2'd2
    } wr_state_t;

    rd_state_t          r_rd_state;
    wr_state_t          r_wr_state;

    logic [3:0]         r_arid;
    logic [ADDR_W-1:0]  r_araddr;
    logic [2:0]         r_arsize;
    logic               r_arvalid;
    logic               r_rready;

    logic [ADDR_W-1:0]  r_awaddr;
    logic [2:0]         r_awsize;
    logic [DATA_W-1:0]  r_wdata;
    logic [STRB_W-1:0]  r_wstrb;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;

    logic w_rd_idle;
    logic w_wr_idle;
    logic w_inst_rd_req;
    logic w_data_rd_req;
    logic w_data_wr_req;
    logic w_data_rd_go;
    logic w_inst_go;
    logic w_wr_go;
    logic w_r_hs;
    logic w_b_hs;
    logic w_aw_done;
    logic w_w_done;

    assign w_rd_idle     = (r_rd_state == RD_IDLE);
    assign w_wr_idle     = (r_wr_state == WR_IDLE);
    assign w_inst_rd_req = inst_sram_req & ~inst_sram_wr;
    assign w_data_rd_req = data_sram_req & ~data_sram_wr;
    assign w_data_wr_req = data_sram_req &  data_sram_wr;

    // A data read and a data write can never be requested together (one wr bit),
    // so waiting for write-idle alone keeps reads ordered behind earlier writes.
    assign w_data_rd_go  = w_rd_idle & w_wr_idle & w_data_rd_req;
    assign w_inst_go     = w_rd_idle & w_inst_rd_req & ~w_data_rd_req;
    assign w_wr_go       = w_wr_idle & w_data_wr_req;

    assign w_r_hs        = r_rready & rvalid;
    assign w_b_hs        = r_bready & bvalid;
    assign w_aw_done     = ~r_awvalid | awready;
    assign w_w_done      = ~r_wvalid  | wready;

    assign inst_sram_addr_ok = w_inst_go;
    assign data_sram_addr_ok = w_data_rd_go | w_wr_go;
    assign inst_sram_data_ok = w_r_hs & (rid == 4'd0);
    assign data_sram_data_ok = (w_r_hs & (rid == 4'd1)) | w_b_hs;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arsize  = r_arsize;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = 4'd1;
    assign awaddr  = r_awaddr;
    assign awsize  = r_awsize;
    assign awvalid = r_awvalid;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = 4'd1;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_state <= RD_IDLE;
            r_arid     <= 4'd0;
            r_araddr   <= '0;
            r_arsize   <= 3'd0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_data_rd_go || w_inst_go) begin
                        r_arid     <= w_data_rd_go ? 4'd1 : 4'd0;
                        r_araddr   <= w_data_rd_go ? data_sram_addr : inst_sram_addr;
                        r_arsize   <= {1'b0, (w_data_rd_go ? data_sram_size : inst_sram_size)};
                        r_arvalid  <= 1'b1;
                        r_rd_state <= RD_AR;
                    end
                end
                RD_AR: begin
                    if (r_arvalid && arready) begin
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_rd_state <= RD_R;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        r_rready   <= 1'b0;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    r_arvalid  <= 1'b0;
                    r_rready   <= 1'b0;
                    r_rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_state <= WR_IDLE;
            r_awaddr   <= '0;
            r_awsize   <= 3'd0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_wr_go) begin
                        r_awaddr   <= data_sram_addr;
                        r_awsize   <= {1'b0, data_sram_size};
                        r_wdata    <= data_sram_wdata;
                        r_wstrb    <= data_sram_wstrb;
                        r_awvalid  <= 1'b1;
                        r_wvalid   <= 1'b1;
                        r_wr_state <= WR_AW_W;
                    end
                end
                WR_AW_W: begin
                    // Address and data channels retire independently, in either order.
                    if (r_awvalid && awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready   <= 1'b1;
                        r_wr_state <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        r_bready   <= 1'b0;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    r_awvalid  <= 1'b0;
                    r_wvalid   <= 1'b0;
                    r_bready   <= 1'b0;
                    r_wr_state <= WR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Bench for cpu_axi_bridge: directed cycle-exact scenarios, then a randomized run against
// a memory/queue reference model with a randomized AXI slave.
module tb_cpu_axi_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, rid, awid, wid, arcache, awcache;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_addr = 32'h0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2; data_sram_addr = 32'h0;
        data_sram_wstrb = 4'h0; data_sram_wdata = 32'h0;
        arready = 1'b0; rid = 4'd0; rdata = 32'h0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    // ---------------- reference memory model for the random run ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        clr_inputs();
        step(); step(); sample();
        n_checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) $display("FAIL rst_valids got=%b exp=00000", {arvalid, rready, awvalid, wvalid, bready}); else n_pass++;
        n_checks++; if ({araddr, awaddr, wdata} !== 96'h0) $display("FAIL rst_addr_data got=%h exp=0", {araddr, awaddr, wdata}); else n_pass++;
        n_checks++; if ({arsize, awsize, arid, wstrb} !== 14'h0) $display("FAIL rst_size_id got=%h exp=0", {arsize, awsize, arid, wstrb}); else n_pass++;
        n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0) $display("FAIL rst_oks got=%b exp=0000", {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}); else n_pass++;
        n_checks++; if ({arlen, arburst, arlock, arcache, arprot} !== {8'd0, 2'b01, 2'd0, 4'd0, 3'd0}) $display("FAIL tie_ar got=%h", {arlen, arburst, arlock, arcache, arprot}); else n_pass++;
        n_checks++; if ({awlen, awburst, awlock, awcache, awprot, awid, wid, wlast} !== {8'd0, 2'b01, 2'd0, 4'd0, 3'd0, 4'd1, 4'd1, 1'b1}) $display("FAIL tie_aw got=%h", {awlen, awburst, awlock, awcache, awprot, awid, wid, wlast}); else n_pass++;
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_inst_read();
        clr_inputs();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0000; inst_sram_size = 2'd2;
        sample();
        n_checks++; if ({inst_sram_addr_ok, arvalid} !== 2'b10) $display("FAIL ir_c0 addr_ok,arvalid got=%b exp=10", {inst_sram_addr_ok, arvalid}); else n_pass++;
        step();
        inst_sram_req = 1'b0; arready = 1'b1;
        sample();
        n_checks++; if ({arvalid, arid, araddr, arsize, inst_sram_data_ok} !== {1'b1, 4'd0, 32'h1c00_0000, 3'd2, 1'b0}) $display("FAIL ir_c1 ar got=%h", {arvalid, arid, araddr, arsize, inst_sram_data_ok}); else n_pass++;
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0c0c;
        sample();
        n_checks++; if ({rready, inst_sram_data_ok, data_sram_data_ok, arvalid} !== 4'b1100) $display("FAIL ir_c2 rready,iok,dok,arvalid got=%b exp=1100", {rready, inst_sram_data_ok, data_sram_data_ok, arvalid}); else n_pass++;
        n_checks++; if (inst_sram_rdata !== 32'h0280_0c0c) $display("FAIL ir_rdata got=%h exp=02800c0c", inst_sram_rdata); else n_pass++;
        step();
        rvalid = 1'b0;
        sample();
        n_checks++; if ({inst_sram_data_ok, rready} !== 2'b00) $display("FAIL ir_c3 iok,rready got=%b exp=00", {inst_sram_data_ok, rready}); else n_pass++;
        // an inst request flagged as a write must be ignored
        step();
        inst_sram_req = 1'b1; inst_sram_wr = 1'b1; inst_sram_addr = 32'h1c00_0010;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_checks++; if ({inst_sram_addr_ok, arvalid} !== 2'b00) $display("FAIL ir_wr_ignored cyc%0d got=%b exp=00", i, {inst_sram_addr_ok, arvalid}); else n_pass++;
            step();
        end
        clr_inputs();
        step();
    endtask

    task automatic test_arbitration();
        clr_inputs();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h100;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h200;
        sample();
        n_checks++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) $display("FAIL arb_c0 dok,iok got=%b exp=10", {data_sram_addr_ok, inst_sram_addr_ok}); else n_pass++;
        step();
        data_sram_req = 1'b0; arready = 1'b1;
        sample();
        n_checks++; if ({arvalid, arid, araddr, inst_sram_addr_ok} !== {1'b1, 4'd1, 32'h200, 1'b0}) $display("FAIL arb_c1 ar got=%h", {arvalid, arid, araddr, inst_sram_addr_ok}); else n_pass++;
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_2222;
        sample();
        n_checks++; if ({data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok, data_sram_rdata} !== {3'b100, 32'h1111_2222}) $display("FAIL arb_c2 got=%h", {data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok, data_sram_rdata}); else n_pass++;
        step();
        rvalid = 1'b0;
        sample();
        n_checks++; if (inst_sram_addr_ok !== 1'b1) $display("FAIL arb_c3 inst addr_ok got=%b exp=1", inst_sram_addr_ok); else n_pass++;
        step();
        inst_sram_req = 1'b0; arready = 1'b1;
        sample();
        n_checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h100}) $display("FAIL arb_c4 ar got=%h", {arvalid, arid, araddr}); else n_pass++;
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h3333_4444;
        sample();
        n_checks++; if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b10, 32'h3333_4444}) $display("FAIL arb_c5 got=%h", {inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata}); else n_pass++;
        step();
        clr_inputs();
        step();
    endtask

    task automatic test_write();
        clr_inputs();
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h80;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'hDEAD_BEEF;
        sample();
        n_checks++; if (data_sram_addr_ok !== 1'b1) $display("FAIL wr_c0 addr_ok got=%b exp=1", data_sram_addr_ok); else n_pass++;
        step();
        data_sram_req = 1'b0; wready = 1'b1;
        sample();
        n_checks++; if ({awvalid, wvalid, bready, awaddr, wdata, wstrb, awsize} !== {3'b110, 32'h80, 32'hDEAD_BEEF, 4'hF, 3'd2}) $display("FAIL wr_c1 got=%h", {awvalid, wvalid, bready, awaddr, wdata, wstrb, awsize}); else n_pass++;
        step();
        wready = 1'b0;
        sample();
        n_checks++; if ({awvalid, wvalid, bready} !== 3'b100) $display("FAIL wr_c2 aw,w,b got=%b exp=100", {awvalid, wvalid, bready}); else n_pass++;
        step();
        awready = 1'b1;
        sample();
        n_checks++; if ({awvalid, wvalid, bready} !== 3'b100) $display("FAIL wr_c3 aw,w,b got=%b exp=100", {awvalid, wvalid, bready}); else n_pass++;
        step();
        awready = 1'b0;
        sample();
        n_checks++; if ({awvalid, wvalid, bready, data_sram_data_ok} !== 4'b0010) $display("FAIL wr_c4 aw,w,b,dok got=%b exp=0010", {awvalid, wvalid, bready, data_sram_data_ok}); else n_pass++;
        step();
        bvalid = 1'b1;
        sample();
        n_checks++; if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b10) $display("FAIL wr_c5 dok,iok got=%b exp=10", {data_sram_data_ok, inst_sram_data_ok}); else n_pass++;
        step();
        bvalid = 1'b0;
        sample();
        n_checks++; if ({bready, data_sram_data_ok} !== 2'b00) $display("FAIL wr_c6 bready,dok got=%b exp=00", {bready, data_sram_data_ok}); else n_pass++;
        step();
    endtask

    task automatic test_raw();
        logic [31:0] mem_word;
        mem_word = 32'h0;
        clr_inputs();
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h80;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'hCAFE_F00D;
        sample();
        n_checks++; if (data_sram_addr_ok !== 1'b1) $display("FAIL raw_wr addr_ok got=%b exp=1", data_sram_addr_ok); else n_pass++;
        step();
        data_sram_wr = 1'b0; data_sram_wdata = 32'h0; awready = 1'b1; wready = 1'b1;
        sample();
        if (wvalid && wready) mem_word = wdata;
        n_checks++; if ({data_sram_addr_ok, awvalid, wvalid} !== 3'b011) $display("FAIL raw_c1 aok,aw,w got=%b exp=011", {data_sram_addr_ok, awvalid, wvalid}); else n_pass++;
        step();
        awready = 1'b0; wready = 1'b0;
        for (int i = 2; i < 4; i++) begin
            sample();
            n_checks++; if ({data_sram_addr_ok, bready} !== 2'b01) $display("FAIL raw_c%0d aok,bready got=%b exp=01", i, {data_sram_addr_ok, bready}); else n_pass++;
            step();
        end
        bvalid = 1'b1;
        sample();
        n_checks++; if ({data_sram_addr_ok, data_sram_data_ok} !== 2'b01) $display("FAIL raw_c4 aok,dok got=%b exp=01", {data_sram_addr_ok, data_sram_data_ok}); else n_pass++;
        step();
        bvalid = 1'b0;
        sample();
        n_checks++; if (data_sram_addr_ok !== 1'b1) $display("FAIL raw_c5 read addr_ok got=%b exp=1", data_sram_addr_ok); else n_pass++;
        step();
        data_sram_req = 1'b0; arready = 1'b1;
        sample();
        n_checks++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h80}) $display("FAIL raw_c6 ar got=%h", {arvalid, arid, araddr}); else n_pass++;
        step();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = mem_word;
        sample();
        n_checks++; if ({data_sram_data_ok, data_sram_rdata} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL raw_c7 dok,rdata got=%h exp=1cafef00d", {data_sram_data_ok, data_sram_rdata}); else n_pass++;
        step();
        clr_inputs();
        step();
    endtask

    task automatic test_simultaneous();
        clr_inputs();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0040;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h90;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'h0102_0304;
        sample();
        n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b11) $display("FAIL sim_c0 iaok,daok got=%b exp=11", {inst_sram_addr_ok, data_sram_addr_ok}); else n_pass++;
        step();
        inst_sram_req = 1'b0; data_sram_req = 1'b0;
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        sample();
        n_checks++; if ({arvalid, awvalid, wvalid} !== 3'b111) $display("FAIL sim_c1 ar,aw,w got=%b exp=111", {arvalid, awvalid, wvalid}); else n_pass++;
        step();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h55AA_55AA; bvalid = 1'b1;
        sample();
        n_checks++; if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b11, 32'h55AA_55AA}) $display("FAIL sim_c2 iok,dok,rdata got=%h", {inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata}); else n_pass++;
        step();
        rvalid = 1'b0; bvalid = 1'b0;
        sample();
        n_checks++; if ({inst_sram_data_ok, data_sram_data_ok, rready, bready} !== 4'b0) $display("FAIL sim_c3 got=%b exp=0000", {inst_sram_data_ok, data_sram_data_ok, rready, bready}); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        clr_inputs();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0080;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'hA0;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'hFFFF_0000;
        sample();
        step();
        inst_sram_req = 1'b0; data_sram_req = 1'b0;
        resetn = 1'b0;
        sample();
        n_checks++; if ({arvalid, awvalid, wvalid} !== 3'b111) $display("FAIL rstm_pre ar,aw,w got=%b exp=111", {arvalid, awvalid, wvalid}); else n_pass++;
        step();
        resetn = 1'b1;
        sample();
        n_checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) $display("FAIL rstm_valids got=%b exp=00000", {arvalid, rready, awvalid, wvalid, bready}); else n_pass++;
        n_checks++; if ({araddr, awaddr, wdata} !== 96'h0) $display("FAIL rstm_regs got=%h exp=0", {araddr, awaddr, wdata}); else n_pass++;
        step();
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00_0100;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h84;
        data_sram_wstrb = 4'h3; data_sram_wdata = 32'h1234_5678;
        sample();
        n_checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b11) $display("FAIL rstm_post aok got=%b exp=11", {inst_sram_addr_ok, data_sram_addr_ok}); else n_pass++;
        step();
        inst_sram_req = 1'b0; data_sram_req = 1'b0;
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        sample();
        n_checks++; if ({arid, araddr, awaddr, wdata, wstrb} !== {4'd0, 32'h1c00_0100, 32'h84, 32'h1234_5678, 4'h3}) $display("FAIL rstm_fields got=%h", {arid, araddr, awaddr, wdata, wstrb}); else n_pass++;
        step();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h0BAD_F00D; bvalid = 1'b1;
        sample();
        n_checks++; if ({inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata} !== {2'b11, 32'h0BAD_F00D}) $display("FAIL rstm_done got=%h", {inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata}); else n_pass++;
        step();
        clr_inputs();
        step();
    endtask

    task automatic test_random();
        bit          inst_pend, data_pend, data_pend_wr, data_rd_out, issuing, drained;
        logic [31:0] inst_pend_addr, data_pend_addr, data_pend_wdata;
        logic [3:0]  data_pend_wstrb;
        logic [31:0] exp_inst_q[$];
        bit          exp_dwr_q[$];
        logic [31:0] exp_dval_q[$];
        logic [35:0] exp_ar_q[$];
        logic [67:0] exp_aw_q[$];
        bit          s_rd_pend, s_rvalid, s_aw_got, s_w_got, s_applied, s_bvalid;
        logic [3:0]  s_rid, s_wstrb;
        logic [31:0] s_rdata, s_awaddr, s_wdata, w_old;
        int          n_txn;
        inst_pend = 0; data_pend = 0; data_pend_wr = 0; data_rd_out = 0; drained = 0;
        inst_pend_addr = 0; data_pend_addr = 0; data_pend_wdata = 0; data_pend_wstrb = 0;
        s_rd_pend = 0; s_rvalid = 0; s_aw_got = 0; s_w_got = 0; s_applied = 0; s_bvalid = 0;
        s_rid = 0; s_wstrb = 0; s_rdata = 0; s_awaddr = 0; s_wdata = 0; n_txn = 0;
        clr_inputs();
        for (int c = 0; c < 3400; c++) begin
            issuing = (c < 3000);
            // core side: a request stays stable until its addr_ok
            if (!inst_pend && issuing && $urandom_range(0, 2) == 0) begin
                inst_pend = 1;
                inst_pend_addr = 32'h1c00_0000 + 32'($urandom_range(0, 63)) * 4;
            end
            if (!data_pend && !data_rd_out && issuing && $urandom_range(0, 2) == 0) begin
                data_pend = 1;
                data_pend_wr = 1'($urandom_range(0, 1));
                data_pend_addr = 32'h0000_1000 + 32'($urandom_range(0, 7)) * 4;
                data_pend_wstrb = 4'($urandom_range(1, 15));
                data_pend_wdata = $urandom;
            end
            inst_sram_req = inst_pend; inst_sram_wr = 1'b0; inst_sram_addr = inst_pend_addr;
            data_sram_req = data_pend; data_sram_wr = data_pend_wr; data_sram_addr = data_pend_addr;
            data_sram_wstrb = data_pend_wstrb; data_sram_wdata = data_pend_wdata;
            // slave side
            arready = !s_rd_pend && ($urandom_range(0, 1) == 1);
            if (s_rd_pend && !s_rvalid && $urandom_range(0, 1) == 1) s_rvalid = 1;
            rvalid = s_rvalid;
            rid = s_rvalid ? s_rid : 4'($urandom_range(0, 15));
            rdata = s_rvalid ? s_rdata : $urandom;
            awready = !s_aw_got && ($urandom_range(0, 1) == 1);
            wready = !s_w_got && ($urandom_range(0, 1) == 1);
            if (s_applied && !s_bvalid && $urandom_range(0, 1) == 1) s_bvalid = 1;
            bvalid = s_bvalid;
            sample();
            if (inst_sram_addr_ok) begin
                n_checks++; if (!inst_pend || (data_sram_req && !data_sram_wr)) $display("FAIL rnd_inst_addr_ok cyc=%0d pend=%0b data_rd_req=%0b", c, inst_pend, data_sram_req && !data_sram_wr); else n_pass++;
                exp_inst_q.push_back(ref_mem.exists(inst_pend_addr) ? ref_mem[inst_pend_addr] : init_word(inst_pend_addr));
                exp_ar_q.push_back({4'd0, inst_pend_addr});
                inst_pend = 0;
            end
            if (data_sram_addr_ok) begin
                n_checks++; if (!data_pend) $display("FAIL rnd_data_addr_ok cyc=%0d unexpected", c); else n_pass++;
                if (data_pend_wr) begin
                    w_old = ref_mem.exists(data_pend_addr) ? ref_mem[data_pend_addr] : init_word(data_pend_addr);
                    ref_mem[data_pend_addr] = merge(w_old, data_pend_wdata, data_pend_wstrb);
                    exp_aw_q.push_back({data_pend_addr, data_pend_wdata, data_pend_wstrb});
                    exp_dwr_q.push_back(1'b1); exp_dval_q.push_back(32'h0);
                end else begin
                    exp_dwr_q.push_back(1'b0);
                    exp_dval_q.push_back(ref_mem.exists(data_pend_addr) ? ref_mem[data_pend_addr] : init_word(data_pend_addr));
                    exp_ar_q.push_back({4'd1, data_pend_addr});
                    data_rd_out = 1;
                end
                data_pend = 0;
            end
            if (inst_sram_data_ok) begin
                n_checks++;
                if (exp_inst_q.size() == 0) $display("FAIL rnd_inst_data_ok cyc=%0d unexpected", c);
                else if (inst_sram_rdata !== exp_inst_q[0]) $display("FAIL rnd_inst_rdata cyc=%0d got=%h exp=%h", c, inst_sram_rdata, exp_inst_q[0]);
                else n_pass++;
                if (exp_inst_q.size() != 0) void'(exp_inst_q.pop_front());
                n_txn++;
            end
            if (data_sram_data_ok) begin
                n_checks++;
                if (exp_dwr_q.size() == 0) $display("FAIL rnd_data_data_ok cyc=%0d unexpected", c);
                else if (!exp_dwr_q[0] && data_sram_rdata !== exp_dval_q[0]) $display("FAIL rnd_data_rdata cyc=%0d got=%h exp=%h", c, data_sram_rdata, exp_dval_q[0]);
                else n_pass++;
                if (exp_dwr_q.size() != 0) begin
                    if (!exp_dwr_q[0]) data_rd_out = 0;
                    void'(exp_dwr_q.pop_front()); void'(exp_dval_q.pop_front());
                end
                n_txn++;
            end
            if (arvalid && arready) begin
                n_checks++;
                if (exp_ar_q.size() == 0) $display("FAIL rnd_ar cyc=%0d unexpected addr=%h", c, araddr);
                else if ({arid, araddr, arsize} !== {exp_ar_q[0], 3'd2}) $display("FAIL rnd_ar cyc=%0d got=%h exp=%h", c, {arid, araddr, arsize}, {exp_ar_q[0], 3'd2});
                else n_pass++;
                if (exp_ar_q.size() != 0) void'(exp_ar_q.pop_front());
                s_rd_pend = 1; s_rid = arid;
                s_rdata = slv_mem.exists(araddr) ? slv_mem[araddr] : init_word(araddr);
            end
            if (rvalid && rready) begin
                s_rd_pend = 0; s_rvalid = 0;
            end
            if (awvalid && awready) begin
                s_aw_got = 1; s_awaddr = awaddr;
            end
            if (wvalid && wready) begin
                s_w_got = 1; s_wdata = wdata; s_wstrb = wstrb;
            end
            if (s_aw_got && s_w_got && !s_applied) begin
                n_checks++;
                if (exp_aw_q.size() == 0) $display("FAIL rnd_aw cyc=%0d unexpected addr=%h", c, s_awaddr);
                else if ({s_awaddr, s_wdata, s_wstrb} !== exp_aw_q[0]) $display("FAIL rnd_aw cyc=%0d got=%h exp=%h", c, {s_awaddr, s_wdata, s_wstrb}, exp_aw_q[0]);
                else n_pass++;
                if (exp_aw_q.size() != 0) void'(exp_aw_q.pop_front());
                w_old = slv_mem.exists(s_awaddr) ? slv_mem[s_awaddr] : init_word(s_awaddr);
                slv_mem[s_awaddr] = merge(w_old, s_wdata, s_wstrb);
                s_applied = 1;
            end
            if (bvalid && bready) begin
                s_aw_got = 0; s_w_got = 0; s_applied = 0; s_bvalid = 0;
            end
            step();
            drained = !inst_pend && !data_pend && exp_inst_q.size() == 0 && exp_dwr_q.size() == 0 &&
                      exp_ar_q.size() == 0 && exp_aw_q.size() == 0 && !s_rd_pend && !s_aw_got && !s_w_got;
            if (!issuing && drained) break;
        end
        n_checks++; if (!drained) $display("FAIL rnd_drain outstanding inst_q=%0d data_q=%0d ar_q=%0d aw_q=%0d", exp_inst_q.size(), exp_dwr_q.size(), exp_ar_q.size(), exp_aw_q.size()); else n_pass++;
        n_checks++; if (n_txn < 200) $display("FAIL rnd_progress completed=%0d exp>=200", n_txn); else n_pass++;
        clr_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_arbitration();
        test_write();
        test_raw();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
